// File: rtl/ann_avmm_pkg.sv
// Shared register map, control bit positions and status layout
// for the ANN Avalon-MM I/O responder.
package ann_avmm_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_IN_DATA  = 3'd2;
    localparam logic [2:0] REG_RESULT   = 3'd3;
    localparam logic [2:0] REG_LEDS     = 3'd4;
    localparam logic [2:0] REG_IRQ_STAT = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int IRQ_DONE    = 0;

    typedef struct packed {
        logic [7:0] fifo_count;
        logic       start_err;
        logic       underflow;
        logic       overflow;
        logic       done;
        logic       hold_valid;
        logic       fifo_empty;
        logic       fifo_full;
        logic       busy;
    } status_t;

endpackage

// File: rtl/ann_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible
// on dout whenever the FIFO is not empty, and dout reads 0 when empty.
module ann_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ann_avmm_io_slave.sv
// Avalon-MM responder bridging HPS software to the ANN datapath:
// input FIFO, result hold register, LED register and done interrupt.
module ann_avmm_io_slave
    import ann_avmm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int LED_W      = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic [DATA_W-1:0]   ann_in_data,
    output logic                ann_in_valid,
    input  logic                ann_in_ready,
    input  logic [DATA_W-1:0]   ann_res_data,
    input  logic                ann_res_valid,
    output logic                ann_res_ready,
    output logic                ann_start,
    input  logic                ann_busy,
    output logic [LED_W-1:0]    leds_export,
    output logic                irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              sel_ctrl, sel_status, sel_in, sel_res;
    logic              sel_leds, sel_irqs;
    logic              wr_ctrl, wr_in, wr_leds, wr_irqs, rd_res;
    logic              start_req, start_ok, clear;
    logic              push, pop, capture;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W-1:0] hold;
    logic              hold_valid;
    logic              irq_en;
    logic              done, overflow, underflow, start_err;
    logic [DATA_W-1:0] rd_val;
    status_t           st;

    assign sel_ctrl   = (avs_address == ADDR_W'(REG_CTRL));
    assign sel_status = (avs_address == ADDR_W'(REG_STATUS));
    assign sel_in     = (avs_address == ADDR_W'(REG_IN_DATA));
    assign sel_res    = (avs_address == ADDR_W'(REG_RESULT));
    assign sel_leds   = (avs_address == ADDR_W'(REG_LEDS));
    assign sel_irqs   = (avs_address == ADDR_W'(REG_IRQ_STAT));

    assign wr_ctrl = avs_write & sel_ctrl;
    assign wr_in   = avs_write & sel_in;
    assign wr_leds = avs_write & sel_leds;
    assign wr_irqs = avs_write & sel_irqs;
    assign rd_res  = avs_read & sel_res;

    assign start_req = wr_ctrl & avs_writedata[CTRL_START];
    assign start_ok  = start_req & avs_byteenable[0] & ~ann_busy;
    assign clear     = wr_ctrl & avs_writedata[CTRL_CLEAR];

    assign ann_in_valid  = ~fifo_empty;
    assign ann_res_ready = ~hold_valid;
    assign pop           = ann_in_valid & ann_in_ready;
    assign push          = wr_in & (~fifo_full | pop);
    assign capture       = ann_res_valid & ~hold_valid;

    ann_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (avs_writedata),
        .dout  (ann_in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        st            = '0;
        st.busy       = ann_busy;
        st.fifo_full  = fifo_full;
        st.fifo_empty = fifo_empty;
        st.hold_valid = hold_valid;
        st.done       = done;
        st.overflow   = overflow;
        st.underflow  = underflow;
        st.start_err  = start_err;
        st.fifo_count = 8'(fifo_count);
    end

    // zero unless a read is presented, so idle readdata stays 0
    always_comb begin
        rd_val = '0;
        if (avs_read) begin
            unique case (1'b1)
                sel_ctrl:   rd_val[CTRL_IRQ_EN] = irq_en;
                sel_status: rd_val[15:0] = st;
                sel_res:    rd_val = hold_valid ? hold : '0;
                sel_leds:   rd_val[LED_W-1:0] = leds_export;
                sel_irqs:   rd_val[IRQ_DONE] = done;
                default:    rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            ann_start         <= 1'b0;
            irq               <= 1'b0;
            irq_en            <= 1'b0;
            leds_export       <= '0;
            hold              <= '0;
        end else begin
            avs_readdata      <= rd_val;
            avs_readdatavalid <= avs_read;
            ann_start         <= start_ok;
            irq               <= done & irq_en;
            if (wr_ctrl) begin
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            end
            for (int i = 0; i < LED_W; i++) begin
                if (wr_leds && avs_byteenable[i/8]) begin
                    leds_export[i] <= avs_writedata[i];
                end
            end
            if (capture) begin
                hold <= ann_res_data;
            end
        end
    end

    // CLEAR outranks every set source in the same cycle
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hold_valid <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            start_err  <= 1'b0;
        end else if (clear) begin
            hold_valid <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            if (capture) begin
                hold_valid <= 1'b1;
            end else if (rd_res) begin
                hold_valid <= 1'b0;
            end
            if (capture) begin
                done <= 1'b1;
            end else if (wr_irqs && avs_writedata[IRQ_DONE]) begin
                done <= 1'b0;
            end
            if (wr_in && !push) begin
                overflow <= 1'b1;
            end
            if (rd_res && !hold_valid) begin
                underflow <= 1'b1;
            end
            if (start_req && !start_ok) begin
                start_err <= 1'b1;
            end
        end
    end

endmodule
